// File: rtl/clint_if.sv
// clint_if: data-bus request/response and interrupt lines between core and CLINT
interface clint_if;
    logic        clint_valid;
    logic        clint_instr;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;
    modport master (
        output clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
        input  clint_rdata, clint_ready, clint_msip, clint_mtip, clint_mtime
    );
    modport slave (
        input  clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
        output clint_rdata, clint_ready, clint_msip, clint_mtip, clint_mtime
    );
endinterface

// File: rtl/clint.sv
// clint: core-local interruptor with RTC-driven mtime, mtimecmp and msip
module clint #(
    parameter logic [31:0] clint_base_addr = 32'h0200_0000,
    parameter int          clk_divider_rtc = 9
) (
    input logic    i_clk,
    input logic    i_rst,
    clint_if.slave bus
);
    logic [31:0] r_rdata, r_div;
    logic        r_ready, r_msip, r_mtip;
    logic [63:0] r_mtime, r_mtimecmp;
    logic [31:0] w_off, w_rdata;
    logic [13:0] w_idx;
    logic        w_tick, w_wr, w_unused;
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = old;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = d[8*i +: 8];
        return m;
    endfunction
    assign w_off    = bus.clint_addr - clint_base_addr;
    assign w_idx    = w_off[15:2];
    assign w_unused = ^{w_off[31:16], w_off[1:0]};
    assign w_tick   = r_div == 32'(clk_divider_rtc);
    // instruction fetches never write, regardless of strobes
    assign w_wr     = bus.clint_valid && !bus.clint_instr && |bus.clint_wstrb;
    assign w_rdata  = w_idx == 14'h0000 ? {31'd0, r_msip} :
                      w_idx == 14'h1000 ? r_mtimecmp[31:0] :
                      w_idx == 14'h1001 ? r_mtimecmp[63:32] :
                      w_idx == 14'h2FFE ? r_mtime[31:0] :
                      w_idx == 14'h2FFF ? r_mtime[63:32] : 32'd0;
    // bus response, register writes, RTC divider, mtime advance and timer compare
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
            r_div      <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
        end else begin
            r_ready <= bus.clint_valid;
            r_rdata <= bus.clint_valid ? w_rdata : 32'd0;
            r_div   <= w_tick ? 32'd0 : r_div + 32'd1;
            r_mtip  <= r_mtime >= r_mtimecmp;
            if (w_wr && w_idx == 14'h0000 && bus.clint_wstrb[0]) r_msip <= bus.clint_wdata[0];
            if (w_wr && w_idx == 14'h1000) r_mtimecmp[31:0] <= merge(r_mtimecmp[31:0], bus.clint_wdata, bus.clint_wstrb);
            if (w_wr && w_idx == 14'h1001) r_mtimecmp[63:32] <= merge(r_mtimecmp[63:32], bus.clint_wdata, bus.clint_wstrb);
            if (w_wr && w_idx == 14'h2FFE) r_mtime[31:0] <= merge(r_mtime[31:0], bus.clint_wdata, bus.clint_wstrb);
            else if (w_wr && w_idx == 14'h2FFF) r_mtime[63:32] <= merge(r_mtime[63:32], bus.clint_wdata, bus.clint_wstrb);
            else if (w_tick) r_mtime <= r_mtime + 64'd1;
        end
    end
    assign bus.clint_rdata = r_rdata;
    assign bus.clint_ready = r_ready;
    assign bus.clint_msip  = r_msip;
    assign bus.clint_mtip  = r_mtip;
    assign bus.clint_mtime = r_mtime;
endmodule

// File: tb/tb_clint.sv
// tb_clint: directed checks of the CLINT bus map, timer, interrupts and reset
module tb_clint;
    localparam logic [31:0] B = 32'h0200_0000;
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;
    int nrdy;
    logic found;
    logic rdy;
    logic [31:0] rd;
    logic [63:0] prev;
    clint_if bus();
    clint #(.clint_base_addr(B), .clk_divider_rtc(9)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic req(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r, output logic y);
        bus.clint_valid = 1'b1;
        bus.clint_addr  = B + off;
        bus.clint_wdata = d;
        bus.clint_wstrb = s;
        @(negedge clk);
        y = bus.clint_ready;
        r = bus.clint_rdata;
        bus.clint_valid = 1'b0;
        bus.clint_wdata = '0;
        bus.clint_wstrb = '0;
    endtask
    initial begin
        rst = 1'b1;
        bus.clint_valid = 1'b0;
        bus.clint_instr = 1'b0;
        bus.clint_addr  = '0;
        bus.clint_wdata = '0;
        bus.clint_wstrb = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", bus.clint_rdata, 0);
        chk("rst_ready", bus.clint_ready, 0);
        chk("rst_msip", bus.clint_msip, 0);
        chk("rst_mtip", bus.clint_mtip, 0);
        chk("rst_mtime", bus.clint_mtime, 0);
        rst = 1'b0;
        nrdy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.clint_ready) nrdy++;
        end
        chk("t1_mtime", bus.clint_mtime, 10);
        chk("t1_mtip", bus.clint_mtip, 0);
        chk("t1_msip", bus.clint_msip, 0);
        chk("t1_no_ready", nrdy, 0);
        req(32'h4000, 0, 4'h0, rd, rdy);
        chk("rst_cmp_lo", rd, 32'hFFFF_FFFF);
        req(32'h0, 32'h1, 4'b0001, rd, rdy);
        chk("t2_wr_ready", rdy, 1);
        chk("t2_msip_set", bus.clint_msip, 1);
        @(negedge clk);
        chk("t2_ready_one_cycle", bus.clint_ready, 0);
        chk("t2_rdata_idle", bus.clint_rdata, 0);
        req(32'h0, 0, 4'h0, rd, rdy);
        chk("t2_rd_ready", rdy, 1);
        chk("t2_rd_msip", rd, 32'h1);
        req(32'h0, 32'h0, 4'b0001, rd, rdy);
        chk("t2_msip_clr", bus.clint_msip, 0);
        req(32'h4000, 32'h14, 4'hF, rd, rdy);
        req(32'h4004, 32'h0, 4'hF, rd, rdy);
        chk("t3_mtip_before", bus.clint_mtip, 0);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus.clint_mtime == 64'd20) found = 1'b1;
        end
        chk("t3_reach20", found, 1);
        chk("t3_mtip_same_cycle", bus.clint_mtip, 0);
        @(negedge clk);
        chk("t3_mtip_rise", bus.clint_mtip, 1);
        req(32'h4000, 32'h100, 4'hF, rd, rdy);
        chk("t3_mtip_hold", bus.clint_mtip, 1);
        @(negedge clk);
        chk("t3_mtip_fall", bus.clint_mtip, 0);
        req(32'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, rdy);
        req(32'hBFFC, 32'h0, 4'hF, rd, rdy);
        chk("t4_mtime_wr", bus.clint_mtime, 64'h0000_0000_FFFF_FFFF);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.clint_mtime != 64'h0000_0000_FFFF_FFFF) found = 1'b1;
        end
        chk("t4_tick_seen", found, 1);
        chk("t4_carry", bus.clint_mtime, 64'h1_0000_0000);
        req(32'hBFF8, 0, 4'h0, rd, rdy);
        chk("t4_rd_lo", rd, 32'h0);
        req(32'hBFFC, 0, 4'h0, rd, rdy);
        chk("t4_rd_hi", rd, 32'h1);
        prev = bus.clint_mtime;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.clint_mtime != prev) found = 1'b1;
        end
        chk("t5_sync", found, 1);
        repeat (9) @(negedge clk);
        req(32'hBFF8, 32'h50, 4'hF, rd, rdy);
        chk("t5_wr_tick", bus.clint_mtime, 64'h1_0000_0050);
        bus.clint_valid = 1'b1;
        bus.clint_addr  = B + 32'h8;
        @(negedge clk);
        chk("t6_b2b_ready0", bus.clint_ready, 1);
        chk("t6_b2b_rdata0", bus.clint_rdata, 0);
        bus.clint_addr = B + 32'hBFF8;
        @(negedge clk);
        chk("t6_b2b_ready1", bus.clint_ready, 1);
        chk("t6_b2b_rdata1", bus.clint_rdata, 32'h50);
        bus.clint_valid = 1'b0;
        @(negedge clk);
        chk("t6_b2b_done", bus.clint_ready, 0);
        repeat (4) @(negedge clk);
        chk("t5_no_incr", bus.clint_mtime, 64'h1_0000_0050);
        req(32'h4000, 32'h1234_5678, 4'hF, rd, rdy);
        req(32'h4000, 32'h0000_AB00, 4'b0010, rd, rdy);
        req(32'h4000, 0, 4'h0, rd, rdy);
        chk("t5_byte_lane", rd, 32'h1234_AB78);
        req(32'h4004, 0, 4'h0, rd, rdy);
        chk("t5_cmp_hi", rd, 32'h0);
        bus.clint_instr = 1'b1;
        req(32'h0, 32'h1, 4'b0001, rd, rdy);
        bus.clint_instr = 1'b0;
        chk("instr_no_write", bus.clint_msip, 0);
        req(32'h0, 32'h1, 4'b0001, rd, rdy);
        chk("t6_msip_pre", bus.clint_msip, 1);
        bus.clint_valid = 1'b1;
        bus.clint_addr  = B + 32'hBFF8;
        #2 rst = 1'b1;
        @(negedge clk);
        bus.clint_valid = 1'b0;
        chk("t6_rst_ready", bus.clint_ready, 0);
        chk("t6_rst_rdata", bus.clint_rdata, 0);
        chk("t6_rst_mtime", bus.clint_mtime, 0);
        chk("t6_rst_msip", bus.clint_msip, 0);
        chk("t6_rst_mtip", bus.clint_mtip, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_ready", bus.clint_ready, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
